// File: rtl/rs_chien_seq.sv
// Sequential Chien search over GF(2^SYMB_WIDTH). Lambda is evaluated at ROOTS_PER_CYCLE codeword positions per beat.
// Define RS_CHIEN_SEQ_PIPE_EN to add a register stage between lane evaluation and the outputs.
package gf_pkg;
  localparam int SYMB_WIDTH = 8;
  localparam int T_LEN      = 16;
  localparam logic [SYMB_WIDTH:0] GF_POLY = 9'h11D;
  localparam int GF_ORDER   = (1 << SYMB_WIDTH) - 1;

  function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                    input logic [SYMB_WIDTH-1:0] b);
    logic [SYMB_WIDTH-1:0] acc;
    logic [SYMB_WIDTH-1:0] sh;
    acc = '0;
    sh  = a;
    for (int n = 0; n < SYMB_WIDTH; n++) begin
      if (b[n]) acc = acc ^ sh;
      sh = sh[SYMB_WIDTH-1] ? ((sh << 1) ^ GF_POLY[SYMB_WIDTH-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  // alpha^e; e is reduced modulo the multiplicative group order
  function automatic logic [SYMB_WIDTH-1:0] gf_pow(input int e);
    logic [SYMB_WIDTH-1:0] p;
    p = SYMB_WIDTH'(1);
    for (int n = 0; n < e % GF_ORDER; n++) p = gf_mult(p, SYMB_WIDTH'(2));
    return p;
  endfunction
endpackage

module rs_chien_seq
  import gf_pkg::*;
#(
  parameter int N_LEN           = 255,
  parameter int ROOTS_PER_CYCLE = 8,
  parameter int CNT_W           = $clog2(N_LEN + 1)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           lambda_vld,
  output logic                           lambda_rdy,
  input  logic [T_LEN:0][SYMB_WIDTH-1:0] error_locator,
  output logic                           pos_vld,
  input  logic                           pos_rdy,
  output logic [ROOTS_PER_CYCLE-1:0]     error_bit_pos,
  output logic                           pos_sop,
  output logic                           pos_eop,
  output logic [CNT_W-1:0]               err_cnt,
  output logic                           fail
);
  localparam int P         = ROOTS_PER_CYCLE;
  localparam int NUM_BEATS = (N_LEN + P - 1) / P;
  localparam int K_W       = $clog2(NUM_BEATS + 1);
  localparam int DEG_W     = $clog2(T_LEN + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [SYMB_WIDTH-1:0] r_reg     [T_LEN+1];
  logic [SYMB_WIDTH-1:0] r_load    [T_LEN+1];
  logic [SYMB_WIDTH-1:0] r_step    [T_LEN+1];
  logic [SYMB_WIDTH-1:0] lane_term [P][T_LEN+1];
  logic [K_W-1:0]        k_reg;
  logic [DEG_W-1:0]      deg_reg, deg_in;
  logic                  lambda0_zero_reg;
  logic [CNT_W-1:0]      cnt_reg, beat_pop;
  logic [P-1:0]          lane_hit;
  logic                  last_chunk, load, issue, accept;

  // All multipliers are by compile-time constants, so each reduces to an XOR network.
  generate
    for (genvar gi = 0; gi <= T_LEN; gi++) begin : g_term
      localparam logic [SYMB_WIDTH-1:0] LOAD_C = gf_pow(GF_ORDER - (gi * (N_LEN - 1)) % GF_ORDER);
      localparam logic [SYMB_WIDTH-1:0] STEP_C = gf_pow(gi * P);
      assign r_load[gi] = gf_mult(error_locator[gi], LOAD_C);
      assign r_step[gi] = gf_mult(r_reg[gi], STEP_C);
      for (genvar gl = 0; gl < P; gl++) begin : g_lane
        localparam logic [SYMB_WIDTH-1:0] LANE_C = gf_pow(gi * gl);
        assign lane_term[gl][gi] = gf_mult(r_reg[gi], LANE_C);
      end
    end
  endgenerate

  always_comb begin
    logic [SYMB_WIDTH-1:0] acc;
    acc      = '0;
    lane_hit = '0;
    for (int i = 0; i < P; i++) begin
      acc = '0;
      for (int j = 0; j <= T_LEN; j++) acc = acc ^ lane_term[i][j];
      lane_hit[i] = (acc == '0) && ((int'(k_reg) * P + i) < N_LEN);
    end
  end

  always_comb begin
    deg_in = '0;
    for (int j = 1; j <= T_LEN; j++)
      if (error_locator[j] != '0) deg_in = DEG_W'(j);
  end

  assign last_chunk = (k_reg == K_W'(NUM_BEATS - 1));
  assign lambda_rdy = (state_reg == IDLE);
  assign load       = lambda_vld && lambda_rdy;
  assign accept     = pos_vld && pos_rdy;

`ifdef RS_CHIEN_SEQ_PIPE_EN
  logic         s2_vld_reg, s2_sop_reg, s2_eop_reg;
  logic [P-1:0] s2_bits_reg;

  // Both stages move together; a stalled output stage freezes the term registers too.
  assign issue = (state_reg == SEARCH) && (!s2_vld_reg || pos_rdy);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s2_vld_reg  <= 1'b0;
      s2_sop_reg  <= 1'b0;
      s2_eop_reg  <= 1'b0;
      s2_bits_reg <= '0;
    end else if (issue) begin
      s2_vld_reg  <= 1'b1;
      s2_sop_reg  <= (k_reg == '0);
      s2_eop_reg  <= last_chunk;
      s2_bits_reg <= lane_hit;
    end else if (accept) begin
      s2_vld_reg  <= 1'b0;
      s2_sop_reg  <= 1'b0;
      s2_eop_reg  <= 1'b0;
      s2_bits_reg <= '0;
    end
  end

  assign pos_vld       = s2_vld_reg;
  assign pos_sop       = s2_sop_reg;
  assign pos_eop       = s2_eop_reg;
  assign error_bit_pos = s2_bits_reg;
`else
  assign issue         = accept;
  assign pos_vld       = (state_reg == SEARCH);
  assign pos_sop       = pos_vld && (k_reg == '0);
  assign pos_eop       = pos_vld && last_chunk;
  assign error_bit_pos = pos_vld ? lane_hit : '0;
`endif

  always_comb begin
    beat_pop = '0;
    for (int i = 0; i < P; i++) beat_pop = beat_pop + CNT_W'(error_bit_pos[i]);
  end

  assign err_cnt = cnt_reg + beat_pop;
  assign fail    = pos_eop && ((int'(err_cnt) != int'(deg_reg)) || lambda0_zero_reg ||
                               ((deg_reg == '0) && (err_cnt != '0)));

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (lambda_vld) state_next = SEARCH;
`ifdef RS_CHIEN_SEQ_PIPE_EN
      SEARCH:  if (issue && last_chunk) state_next = DRAIN;
      DRAIN:   if (accept && pos_eop) state_next = IDLE;
`else
      SEARCH:  if (accept && pos_eop) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg        <= IDLE;
      k_reg            <= '0;
      deg_reg          <= '0;
      lambda0_zero_reg <= 1'b0;
      cnt_reg          <= '0;
      for (int j = 0; j <= T_LEN; j++) r_reg[j] <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        for (int j = 0; j <= T_LEN; j++) r_reg[j] <= r_load[j];
        k_reg            <= '0;
        deg_reg          <= deg_in;
        lambda0_zero_reg <= (error_locator[0] == '0);
        cnt_reg          <= '0;
      end else begin
        if (issue) begin
          for (int j = 0; j <= T_LEN; j++) r_reg[j] <= r_step[j];
          k_reg <= k_reg + K_W'(1);
        end
        if (accept) cnt_reg <= err_cnt;
      end
    end
  end
endmodule

// File: tb/tb_rs_chien_seq.sv
// Self-checking bench for rs_chien_seq: GF(2^8)/0x11D, N=255, P=8, T=16, with a table-driven reference model.
module tb_rs_chien_seq;
  localparam int N  = 255;
  localparam int P  = 8;
  localparam int NB = 32;
  localparam int T  = 16;
  localparam int CW = 8;
`ifdef RS_CHIEN_SEQ_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [T:0][7:0] lam_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          lambda_vld = 1'b0;
  logic          lambda_rdy;
  lam_t          error_locator = '0;
  logic          pos_vld;
  logic          pos_rdy = 1'b1;
  logic [P-1:0]  error_bit_pos;
  logic          pos_sop, pos_eop, fail;
  logic [CW-1:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_t [255];
  int log_t [256];
  int epos [$];

  lam_t         lam, lam3, lam_b;
  logic [255:0] emap;
  int           ecnt, a1, e1, a2, e2, v, npos, pick;
  bit           efl, found, dup;

  rs_chien_seq #(.N_LEN(N), .ROOTS_PER_CYCLE(P)) dut (
    .aclk(aclk), .aresetn(aresetn), .lambda_vld(lambda_vld), .lambda_rdy(lambda_rdy),
    .error_locator(error_locator), .pos_vld(pos_vld), .pos_rdy(pos_rdy),
    .error_bit_pos(error_bit_pos), .pos_sop(pos_sop), .pos_eop(pos_eop),
    .err_cnt(err_cnt), .fail(fail)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  // Multiply a polynomial by (1 + X*x); terms beyond x^T are dropped.
  function automatic lam_t mul_lin(input lam_t l, input int x);
    lam_t r;
    r = l;
    for (int j = 1; j <= T; j++) r[j] = l[j] ^ 8'(gmul(x, int'(l[j-1])));
    return r;
  endfunction

  function automatic lam_t build_lam();
    lam_t l;
    l = '0;
    l[0] = 8'h01;
    foreach (epos[n]) l = mul_lin(l, exp_t[(N - 1 - epos[n]) % 255]);
    return l;
  endfunction

  // Direct evaluation: position p is in error iff Lambda(alpha^-(N-1-p)) == 0.
  task automatic model(input lam_t l, output logic [255:0] m, output int cnt, output bit fl);
    int deg, x, y;
    m = '0;
    cnt = 0;
    deg = 0;
    for (int j = 1; j <= T; j++) if (l[j] != 8'h00) deg = j;
    for (int p = 0; p < N; p++) begin
      x = exp_t[(255 - (N - 1 - p)) % 255];
      y = 0;
      for (int j = T; j >= 0; j--) y = gmul(y, x) ^ int'(l[j]);
      if (y == 0) begin
        m[p] = 1'b1;
        cnt++;
      end
    end
    fl = (cnt != deg) || (l[0] == 8'h00) || (deg == 0 && cnt != 0);
  endtask

  // Called and returns on a falling edge.
  task automatic run_block(input string name, input lam_t l, input bit rand_rdy,
                           input int abort_at, input bit keep_vld,
                           output int acc_cyc, output int eop_cyc);
    logic [255:0] m;
    int           mcnt, run, b, lat, w;
    bit           mfl, stalled;
    logic [63:0]  snap;
    logic [P-1:0] eb;
    model(l, m, mcnt, mfl);
    acc_cyc = -1;
    eop_cyc = -1;
    error_locator = l;
    lambda_vld = 1'b1;
    pos_rdy = 1'b1;
    w = 0;
    while (!lambda_rdy && w < 200) begin
      @(negedge aclk);
      w++;
    end
    check({name, " accept"}, 64'(lambda_rdy), 64'(1));
    if (!lambda_rdy) begin
      lambda_vld = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    @(negedge aclk);
    if (!keep_vld) lambda_vld = 1'b0;
    lat = 1;
    while (!pos_vld && lat < 10) begin
      @(negedge aclk);
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(LAT));
    b = 0;
    run = 0;
    stalled = 1'b0;
    snap = '0;
    w = 0;
    while (b < NB && w < 2000) begin
      if (b == abort_at) begin
        aresetn = 1'b0;
        @(negedge aclk);
        check({name, " abort pos_vld"}, 64'(pos_vld), 64'(0));
        check({name, " abort lambda_rdy"}, 64'(lambda_rdy), 64'(1));
        check({name, " abort err_cnt"}, 64'(err_cnt), 64'(0));
        aresetn = 1'b1;
        lambda_vld = 1'b0;
        pos_rdy = 1'b1;
        @(negedge aclk);
        check({name, " post-abort pos_vld"}, 64'(pos_vld), 64'(0));
        check({name, " post-abort lambda_rdy"}, 64'(lambda_rdy), 64'(1));
        $display("[TB] %s: aborted by reset at beat %0d", name, b);
        return;
      end
      if (stalled)
        check($sformatf("%s stall hold beat %0d", name, b),
              64'({pos_vld, error_bit_pos, pos_sop, pos_eop, fail, err_cnt}), snap);
      snap = 64'({pos_vld, error_bit_pos, pos_sop, pos_eop, fail, err_cnt});
      pos_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pos_rdy) begin
        eb = m[b*P +: P];
        run += $countones(eb);
        check($sformatf("%s vld beat %0d", name, b), 64'(pos_vld), 64'(1));
        check($sformatf("%s bits beat %0d", name, b), 64'(error_bit_pos), 64'(eb));
        check($sformatf("%s sop beat %0d", name, b), 64'(pos_sop), 64'(b == 0));
        check($sformatf("%s eop beat %0d", name, b), 64'(pos_eop), 64'(b == NB - 1));
        check($sformatf("%s err_cnt beat %0d", name, b), 64'(err_cnt), 64'(run));
        check($sformatf("%s fail beat %0d", name, b), 64'(fail), 64'((b == NB - 1) && mfl));
        if (b == NB - 1) eop_cyc = cyc + 1;
        b++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      if (b < NB) @(negedge aclk);
      w++;
    end
    check({name, " beat count"}, 64'(b), 64'(NB));
    $display("[TB] %s: accepted cycle %0d, beats=%0d, err_cnt=%0d, fail=%0d",
             name, acc_cyc, b, run, mfl);
  endtask

  initial begin
    v = 1;
    for (int e = 0; e < 255; e++) begin
      exp_t[e] = v;
      log_t[v] = e;
      v = v << 1;
      if (v >= 256) v = v ^ 'h11D;
    end
    log_t[0] = 0;

    repeat (3) @(negedge aclk);
    check("reset lambda_rdy", 64'(lambda_rdy), 64'(1));
    check("reset pos_vld", 64'(pos_vld), 64'(0));
    check("reset pos_sop", 64'(pos_sop), 64'(0));
    check("reset pos_eop", 64'(pos_eop), 64'(0));
    check("reset bits", 64'(error_bit_pos), 64'(0));
    check("reset err_cnt", 64'(err_cnt), 64'(0));
    check("reset fail", 64'(fail), 64'(0));
    aresetn = 1'b1;
    @(negedge aclk);

    lam = '0;
    lam[0] = 8'h01;
    run_block("no_errors", lam, 1'b0, -1, 1'b0, a1, e1);

    epos = {0};
    lam = build_lam();
    run_block("err_p0", lam, 1'b0, -1, 1'b0, a1, e1);

    epos = {3, 200};
    lam3 = build_lam();
    run_block("err_p3_p200", lam3, 1'b0, -1, 1'b0, a1, e1);

    // Degree-3 locator with exactly one root: linear factor times a root-free quadratic.
    found = 1'b0;
    lam = '0;
    for (int t = 0; t < 1000 && !found; t++) begin
      lam = '0;
      lam[0] = 8'h01;
      lam[1] = 8'($urandom_range(1, 255));
      lam[2] = 8'($urandom_range(1, 255));
      model(lam, emap, ecnt, efl);
      if (ecnt == 0) found = 1'b1;
    end
    lam = mul_lin(lam, exp_t[1]);
    run_block("deg3_one_root", lam, 1'b0, -1, 1'b0, a1, e1);

    lam = '0;
    lam[1] = 8'h01;
    lam[2] = 8'($urandom_range(0, 255));
    run_block("lambda0_zero", lam, 1'b0, -1, 1'b0, a1, e1);

    lam = '0;
    run_block("all_zero", lam, 1'b0, -1, 1'b0, a1, e1);

    run_block("rand_rdy_p3_p200", lam3, 1'b1, -1, 1'b0, a1, e1);
    run_block("abort", lam3, 1'b0, 10, 1'b0, a1, e1);
    run_block("after_abort", lam3, 1'b1, -1, 1'b0, a1, e1);

    epos = {0};
    lam_b = build_lam();
    run_block("b2b_first", lam_b, 1'b0, -1, 1'b1, a1, e1);
    run_block("b2b_second", lam3, 1'b0, -1, 1'b0, a2, e2);
    check("b2b accept gap", 64'(a2 - e1), 64'(1));

    for (int n = 0; n < 6; n++) begin
      epos.delete();
      npos = $urandom_range(0, T);
      while (epos.size() < npos) begin
        pick = $urandom_range(0, N - 1);
        dup = 1'b0;
        foreach (epos[q]) if (epos[q] == pick) dup = 1'b1;
        if (!dup) epos.push_back(pick);
      end
      lam = build_lam();
      run_block($sformatf("random_%0d_errs_%0d", n, npos), lam, 1'(n % 2), -1, 1'b0, a1, e1);
    end

    for (int j = 0; j <= T; j++) lam[j] = 8'($urandom_range(0, 255));
    run_block("random_poly", lam, 1'b1, -1, 1'b0, a1, e1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
